// File: rtl/dcpu16_cpu_core.sv
// Multi-cycle DCPU-16 v1.1 core. fs carries instruction/next-word fetches and all
// memory write-backs, ab carries operand reads; at most one transfer is in flight.
module dcpu16_cpu_core (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] fs_adr,
  output logic [15:0] fs_dto,
  output logic        fs_stb,
  output logic        fs_wre,
  input  logic [15:0] fs_dti,
  input  logic        fs_ack,
  output logic [15:0] ab_adr,
  output logic [15:0] ab_dto,
  output logic        ab_stb,
  output logic        ab_wre,
  input  logic [15:0] ab_dti,
  input  logic        ab_ack,
  output logic [15:0] ireg,
  output logic [15:0] regSP,
  output logic [15:0] src,
  output logic [15:0] tgt
);
  typedef enum logic [2:0] {IDLE, FETCH, NXTA, NXTB, RDA, RDB, EXE, WB} state_t;

  state_t      state, after_fetch, after_nxta, after_nxtb, after_rda;
  logic [15:0] file [0:7];
  logic [15:0] pc, sp, o, nw_a, nw_b, mem_a, mem_b, wb_adr, wb_dat;
  logic        skip;

  function automatic logic needs_nw(input logic [5:0] c);
    return (c[5:3] == 3'b010) || (c == 6'h1e) || (c == 6'h1f);
  endfunction

  function automatic logic is_mem(input logic [5:0] c);
    return (c[5:3] == 3'b001) || (c[5:3] == 3'b010) ||
           (c == 6'h18) || (c == 6'h19) || (c == 6'h1a) || (c == 6'h1e);
  endfunction

  function automatic logic [15:0] eff_adr(input logic [5:0] c, input logic [15:0] nw,
                                          input logic [15:0] r, input logic [15:0] s);
    if (c[5:3] == 3'b001) return r;
    if (c[5:3] == 3'b010) return nw + r;
    if (c == 6'h1a) return s - 16'd1;
    if (c == 6'h1e) return nw;
    return s;
  endfunction

  function automatic logic [15:0] sp_after(input logic [5:0] c, input logic [15:0] s);
    if (c == 6'h18) return s + 16'd1;
    if (c == 6'h1a) return s - 16'd1;
    return s;
  endfunction

  function automatic logic [15:0] opnd_val(input logic [5:0] c, input logic [15:0] r,
                                           input logic [15:0] m, input logic [15:0] nw,
                                           input logic [15:0] s, input logic [15:0] p,
                                           input logic [15:0] ov);
    if (c[5]) return {11'd0, c[4:0]};
    if (c[5:3] == 3'b000) return r;
    case (c)
      6'h1b:   return s;
      6'h1c:   return p;
      6'h1d:   return ov;
      6'h1f:   return nw;
      default: return m;
    endcase
  endfunction

  // During FETCH the operand fields come straight from the word being returned.
  logic [15:0] iw, val_a, val_b, ea_a, ea_b, sp_a, sp_b;
  logic [5:0]  code_a, code_b;
  logic        nb, jsr, is_if;

  assign iw     = (state == FETCH) ? fs_dti : ireg;
  assign nb     = (iw[3:0] == 4'h0);
  assign code_a = nb ? iw[15:10] : iw[9:4];
  assign code_b = nb ? 6'h20 : iw[15:10];
  assign jsr    = nb && (iw[9:4] == 6'h01);
  assign is_if  = !nb && (iw[3:2] == 2'b11);
  assign sp_a   = sp_after(code_a, sp);
  assign sp_b   = sp_after(code_b, sp_a);
  assign ea_a   = eff_adr(code_a, nw_a, file[code_a[2:0]], sp);
  assign ea_b   = eff_adr(code_b, nw_b, file[code_b[2:0]], sp_a);
  assign val_a  = opnd_val(code_a, file[code_a[2:0]], mem_a, nw_a, sp, pc, o);
  assign val_b  = opnd_val(code_b, file[code_b[2:0]], mem_b, nw_b, sp, pc, o);

  always_comb begin
    after_rda   = is_mem(code_b) ? RDB : EXE;
    after_nxtb  = skip ? FETCH : (is_mem(code_a) ? RDA : after_rda);
    after_nxta  = needs_nw(code_b) ? NXTB : after_nxtb;
    after_fetch = needs_nw(code_a) ? NXTA : after_nxta;
  end

  logic [15:0] res, o_res;
  logic        o_wr, cond;
  logic [16:0] sum, dif;
  logic [31:0] prod, shl_v, shr_v, quo;

  always_comb begin
    sum   = {1'b0, val_a} + {1'b0, val_b};
    dif   = {1'b0, val_a} - {1'b0, val_b};
    prod  = {16'd0, val_a} * {16'd0, val_b};
    shl_v = {16'd0, val_a} << val_b;
    shr_v = {val_a, 16'd0} >> val_b;
    // (a<<16)/b gives the quotient in the top half and the DIV overflow in the bottom.
    quo   = (val_b == 16'd0) ? 32'd0 : {val_a, 16'd0} / {16'd0, val_b};
    res   = val_b;
    o_res = o;
    o_wr  = 1'b0;
    cond  = 1'b1;
    case (ireg[3:0])
      4'h2: begin res = sum[15:0];   o_res = {15'd0, sum[16]}; o_wr = 1'b1; end
      4'h3: begin res = dif[15:0];   o_res = {16{dif[16]}};    o_wr = 1'b1; end
      4'h4: begin res = prod[15:0];  o_res = prod[31:16];      o_wr = 1'b1; end
      4'h5: begin res = quo[31:16];  o_res = quo[15:0];        o_wr = 1'b1; end
      4'h6: res = (val_b == 16'd0) ? 16'd0 : val_a % val_b;
      4'h7: begin res = shl_v[15:0]; o_res = shl_v[31:16];     o_wr = 1'b1; end
      4'h8: begin res = shr_v[31:16]; o_res = shr_v[15:0];     o_wr = 1'b1; end
      4'h9: res = val_a & val_b;
      4'ha: res = val_a | val_b;
      4'hb: res = val_a ^ val_b;
      4'hc: cond = (val_a == val_b);
      4'hd: cond = (val_a != val_b);
      4'he: cond = (val_a > val_b);
      4'hf: cond = ((val_a & val_b) != 16'd0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= 16'd0;
      sp    <= 16'd0;
      o     <= 16'd0;
      ireg  <= 16'd0;
      skip  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: if (fs_ack) begin
          ireg  <= fs_dti;
          pc    <= pc + 16'd1;
          state <= after_fetch;
          if (after_fetch == FETCH) skip <= 1'b0;
        end
        NXTA: if (fs_ack) begin
          pc    <= pc + 16'd1;
          state <= after_nxta;
          if (after_nxta == FETCH) skip <= 1'b0;
        end
        NXTB: if (fs_ack) begin
          pc    <= pc + 16'd1;
          state <= after_nxtb;
          if (after_nxtb == FETCH) skip <= 1'b0;
        end
        RDA: if (ab_ack) state <= after_rda;
        RDB: if (ab_ack) state <= EXE;
        EXE: begin
          state <= FETCH;
          sp    <= sp_b;
          if (jsr) begin
            sp    <= sp_b - 16'd1;
            pc    <= val_a;
            state <= WB;
          end else if (is_if) begin
            skip <= ~cond;
          end else if (!nb) begin
            if (o_wr) o <= o_res;
            case (code_a)
              6'h1b:   sp <= res;
              6'h1c:   pc <= res;
              6'h1d:   o  <= res;
              default: if (is_mem(code_a)) state <= WB;
            endcase
          end
        end
        WB: if (fs_ack) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      NXTA: if (fs_ack) nw_a <= fs_dti;
      NXTB: if (fs_ack) nw_b <= fs_dti;
      RDA:  if (ab_ack) mem_a <= ab_dti;
      RDB:  if (ab_ack) mem_b <= ab_dti;
      EXE: begin
        if (jsr) begin
          wb_adr <= sp_b - 16'd1;
          wb_dat <= pc;
        end else if (!nb && !is_if) begin
          if (code_a[5:3] == 3'b000) file[code_a[2:0]] <= res;
          wb_adr <= ea_a;
          wb_dat <= res;
        end
      end
      default: ;
    endcase
  end

  assign fs_stb = (state == FETCH) || (state == NXTA) || (state == NXTB) || (state == WB);
  assign fs_wre = (state == WB);
  assign fs_adr = (state == WB) ? wb_adr : pc;
  assign fs_dto = (state == WB) ? wb_dat : 16'd0;
  assign ab_stb = (state == RDA) || (state == RDB);
  assign ab_adr = (state == RDA) ? ea_a : ((state == RDB) ? ea_b : 16'd0);
  assign ab_dto = 16'd0;
  assign ab_wre = 1'b0;
  assign regSP  = sp;
  assign src    = val_b;
  assign tgt    = val_a;
endmodule

// File: tb/tb_dcpu16_cpu_core.sv
// Bench for dcpu16_cpu_core: dual-port registered RAM model with programmable
// ack latency, a table of short programs, and hand-written multi-cycle sequences.
module tb_dcpu16_cpu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fs_adr, fs_dto, fs_dti, ab_adr, ab_dto, ab_dti;
  logic        fs_stb, fs_wre, fs_ack, ab_stb, ab_wre, ab_ack;
  logic [15:0] ireg, regSP, src, tgt;

  dcpu16_cpu_core dut (
    .clk(clk), .rst(rst),
    .fs_adr(fs_adr), .fs_dto(fs_dto), .fs_stb(fs_stb), .fs_wre(fs_wre),
    .fs_dti(fs_dti), .fs_ack(fs_ack),
    .ab_adr(ab_adr), .ab_dto(ab_dto), .ab_stb(ab_stb), .ab_wre(ab_wre),
    .ab_dti(ab_dti), .ab_ack(ab_ack),
    .ireg(ireg), .regSP(regSP), .src(src), .tgt(tgt)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] prog_img [0:15];
  logic        ld = 1'b1;
  int          fs_wait = 0, ab_wait = 0;
  int          fs_cnt, ab_cnt, wr_cnt;
  logic [15:0] wr_adr, wr_dat;

  // RAM reloads from prog_img while ld is high; otherwise it serves both ports.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 65536; i++) mem[i] <= (i < 16) ? prog_img[i[3:0]] : 16'h0000;
      wr_cnt <= 0;
      fs_ack <= 1'b0;
      ab_ack <= 1'b0;
      fs_cnt <= 0;
      ab_cnt <= 0;
    end else begin
      if (fs_stb && !fs_ack) begin
        if (fs_cnt >= fs_wait) begin
          fs_ack <= 1'b1;
          fs_cnt <= 0;
          fs_dti <= mem[fs_adr];
          if (fs_wre) begin
            mem[fs_adr] <= fs_dto;
            wr_cnt <= wr_cnt + 1;
            wr_adr <= fs_adr;
            wr_dat <= fs_dto;
          end
        end else fs_cnt <= fs_cnt + 1;
      end else begin
        fs_ack <= 1'b0;
        fs_cnt <= 0;
      end
      if (ab_stb && !ab_ack) begin
        if (ab_cnt >= ab_wait) begin
          ab_ack <= 1'b1;
          ab_cnt <= 0;
          ab_dti <= mem[ab_adr];
        end else ab_cnt <= ab_cnt + 1;
      end else begin
        ab_ack <= 1'b0;
        ab_cnt <= 0;
      end
    end
  end

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic set_prog(input logic [0:5][15:0] p);
    for (int i = 0; i < 16; i++) prog_img[i] = 16'h0000;
    for (int i = 0; i < 6; i++) prog_img[i] = p[i];
  endtask

  task automatic start(input logic [0:5][15:0] p);
    set_prog(p);
    rst = 1'b1;
    ld  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ld  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_to(input logic [15:0] stop, input string nm);
    int n;
    n = 0;
    while (!(fs_stb && !fs_wre && fs_adr == stop) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_reach_pc"}, {15'd0, n < 400}, 16'd1);
  endtask

  typedef struct {
    string             nm;
    logic [0:5][15:0]  prog;
    logic [15:0]       stop;
    logic [15:0]       a;
    logic [15:0]       o;
    logic [15:0]       sp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic [0:5][15:0] p, input logic [15:0] stop,
                     input logic [15:0] a, input logic [15:0] o, input logic [15:0] sp);
    vec_t v;
    v.nm = nm; v.prog = p; v.stop = stop; v.a = a; v.o = o; v.sp = sp;
    vq.push_back(v);
  endtask

  initial begin
    add("set_lit",   {16'h7c01, 16'h0030, 16'h0,    16'h0,    16'h0,    16'h0},    16'd2, 16'h0030, 16'h0000, 16'h0000);
    add("add_carry", {16'h7c01, 16'hffff, 16'h8402, 16'h0,    16'h0,    16'h0},    16'd3, 16'h0000, 16'h0001, 16'h0000);
    add("sub_borrow",{16'h7c01, 16'hffff, 16'h8402, 16'h8403, 16'h0,    16'h0},    16'd4, 16'hffff, 16'hffff, 16'h0000);
    add("ifn_skip",  {16'h8401, 16'h840d, 16'h7c01, 16'h1234, 16'h0,    16'h0},    16'd4, 16'h0001, 16'h0000, 16'h0000);
    add("div_zero",  {16'h7c01, 16'hffff, 16'h8402, 16'h9401, 16'h8011, 16'h0405}, 16'd6, 16'h0000, 16'h0000, 16'h0000);
    add("mul_ovf",   {16'h7c01, 16'h1000, 16'h7c04, 16'h0020, 16'h0,    16'h0},    16'd4, 16'h0000, 16'h0002, 16'h0000);
    add("shr",       {16'h7c01, 16'h00f0, 16'ha008, 16'h0,    16'h0,    16'h0},    16'd3, 16'h0000, 16'hf000, 16'h0000);
    add("div_7_2",   {16'h9c01, 16'h8805, 16'h0,    16'h0,    16'h0,    16'h0},    16'd2, 16'h0003, 16'h8000, 16'h0000);
    add("ife_pass",  {16'h8c01, 16'h8c0c, 16'ha401, 16'h0,    16'h0,    16'h0},    16'd3, 16'h0009, 16'h0000, 16'h0000);
    add("push_pop",  {16'h9da1, 16'h6001, 16'h0,    16'h0,    16'h0,    16'h0},    16'd2, 16'h0007, 16'h0000, 16'h0000);
    add("shl",       {16'h7c01, 16'h8001, 16'h8407, 16'h0,    16'h0,    16'h0},    16'd3, 16'h0002, 16'h0001, 16'h0000);
    add("xor",       {16'h7c01, 16'hff0f, 16'h7c0b, 16'h0ff0, 16'h0,    16'h0},    16'd4, 16'hf0ff, 16'h0000, 16'h0000);
    add("mod_zero",  {16'ha401, 16'h8006, 16'h0,    16'h0,    16'h0,    16'h0},    16'd2, 16'h0000, 16'h0000, 16'h0000);

    // Reset hold, first fetch address, then SET A / SET [next] write-back on fs.
    set_prog({16'h7c01, 16'h0030, 16'h7de1, 16'h1000, 16'h0020, 16'h0});
    rst = 1'b1;
    ld  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_fs_stb", {15'd0, fs_stb}, 16'd0);
    chk("rst_ab_stb", {15'd0, ab_stb}, 16'd0);
    chk("rst_fs_wre", {15'd0, fs_wre}, 16'd0);
    chk("rst_regSP", regSP, 16'h0000);
    chk("rst_ireg", ireg, 16'h0000);
    chk("rst_fs_adr", fs_adr, 16'h0000);
    ld  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_fs_stb", {15'd0, fs_stb}, 16'd1);
    chk("first_fs_adr", fs_adr, 16'h0000);
    run_to(16'd5, "set_mem");
    chk("set_mem_A", dut.file[0], 16'h0030);
    chk("set_mem_wr_cnt", wr_cnt[15:0], 16'd1);
    chk("set_mem_wr_adr", wr_adr, 16'h1000);
    chk("set_mem_wr_dat", wr_dat, 16'h0020);
    chk("set_mem_ram", mem[16'h1000], 16'h0020);

    for (int k = 0; k < vq.size(); k++) begin
      fs_wait = k % 3;
      ab_wait = (k + 1) % 2;
      start(vq[k].prog);
      run_to(vq[k].stop, vq[k].nm);
      chk({vq[k].nm, "_A"}, dut.file[0], vq[k].a);
      chk({vq[k].nm, "_O"}, dut.o, vq[k].o);
      chk({vq[k].nm, "_SP"}, regSP, vq[k].sp);
    end

    // JSR from SP=0 pushes the return address at 0xffff and jumps.
    fs_wait = 1;
    ab_wait = 0;
    start({16'hc010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    run_to(16'h0010, "jsr");
    chk("jsr_ram", mem[16'hffff], 16'h0001);
    chk("jsr_wr_adr", wr_adr, 16'hffff);
    chk("jsr_regSP", regSP, 16'hffff);

    // Reset asserted while a write-back waits for ack must drop the strobe and never write.
    fs_wait = 3;
    start({16'h7de1, 16'h2000, 16'h0055, 16'h0, 16'h0, 16'h0});
    begin
      int n;
      n = 0;
      while (!(fs_stb && fs_wre) && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("abort_reach_wb", {15'd0, n < 200}, 16'd1);
    end
    rst = 1'b1;
    #1;
    chk("abort_fs_stb", {15'd0, fs_stb}, 16'd0);
    chk("abort_fs_wre", {15'd0, fs_wre}, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_wr_cnt", wr_cnt[15:0], 16'd0);
    chk("abort_ram", mem[16'h2000], 16'h0000);
    chk("abort_regSP", regSP, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
